// File: rtl/phys_reg_alloc_ctrl.sv
// Physical-register free-list allocator: seeds the free list and clears the map table after reset,
// then grants cells to rename ports and recycles cells freed at commit. Optional PHYS_ALLOC_STATS_EN adds stall/grant counters.
module phys_reg_alloc_ctrl #(
    parameter int CELLS           = 128,
    parameter int VIRT_COUNT      = 256,
    parameter int VIRT_ADDR_WIDTH = $clog2(VIRT_COUNT),
    parameter int PHYS_ADDR_WIDTH = $clog2(CELLS),
    parameter int ALLOC_PORTS     = 4,
    parameter int FREE_PORTS      = 4,
    parameter int CNT_WIDTH       = $clog2(CELLS + 1)
) (
    input  logic                                             clk,
    input  logic                                             sync_rst,
    input  logic                                             clk_en,
    input  logic [ALLOC_PORTS-1:0]                           alloc_req,
    input  logic [ALLOC_PORTS-1:0][VIRT_ADDR_WIDTH-1:0]      alloc_tag,
    output logic                                             alloc_ready,
    output logic [ALLOC_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]      alloc_phys,
    input  logic [FREE_PORTS-1:0]                            free_valid,
    input  logic [FREE_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]       free_phys,
    output logic [ALLOC_PORTS-1:0]                           mt_wr_en,
    output logic [ALLOC_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]      mt_wr_addr,
    output logic [ALLOC_PORTS-1:0][VIRT_ADDR_WIDTH-1:0]      mt_tag,
    output logic [CNT_WIDTH-1:0]                             free_count,
    output logic                                             init_done,
    output logic                                             err_overflow
`ifdef PHYS_ALLOC_STATS_EN
    ,
    output logic [31:0]                                      stall_cycles,
    output logic [31:0]                                      alloc_total
`endif
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0]       ALLOC_MIN = CNT_WIDTH'(ALLOC_PORTS);
    localparam logic [CNT_WIDTH:0]         CELLS_W   = (CNT_WIDTH + 1)'(CELLS);
    localparam logic [PHYS_ADDR_WIDTH-1:0] LAST_IDX  = PHYS_ADDR_WIDTH'(CELLS - 1);

    state_t                                      state_q, state_d;
    logic [PHYS_ADDR_WIDTH-1:0]                  init_idx_q, init_idx_d;
    logic [PHYS_ADDR_WIDTH-1:0]                  head_q, head_d;
    logic [PHYS_ADDR_WIDTH-1:0]                  tail_q, tail_d;
    logic [CNT_WIDTH-1:0]                        count_q, count_d;
    logic                                        err_q, err_d;
    logic [ALLOC_PORTS-1:0]                      mt_en_q, mt_en_d;
    logic [ALLOC_PORTS-1:0][PHYS_ADDR_WIDTH-1:0] mt_addr_q, mt_addr_d;
    logic [ALLOC_PORTS-1:0][VIRT_ADDR_WIDTH-1:0] mt_tag_q, mt_tag_d;

    logic [PHYS_ADDR_WIDTH-1:0]                  free_list [CELLS];
    logic [FREE_PORTS-1:0]                       list_we;
    logic [FREE_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]  list_waddr;
    logic [FREE_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]  list_wdata;

    logic                                        grant;
    logic                                        overflow;
    logic [CNT_WIDTH:0]                          count_raw;
    int                                          rank;
    int                                          n_grant;
    int                                          n_free_req;
    int                                          n_push;
    int                                          capacity;

    function automatic logic [PHYS_ADDR_WIDTH-1:0] wrap_add(input logic [PHYS_ADDR_WIDTH-1:0] base,
                                                            input int off);
        int s;
        s = int'(base) + off;
        if (s >= CELLS) s = s - CELLS;
        return PHYS_ADDR_WIDTH'(s);
    endfunction

    // Next-state logic; with clk_en low every *_d defaults to its *_q, freezing the block.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        err_d      = err_q;
        mt_en_d    = mt_en_q;
        mt_addr_d  = mt_addr_q;
        mt_tag_d   = mt_tag_q;
        list_we    = '0;
        list_waddr = '0;
        list_wdata = '0;
        overflow   = 1'b0;
        count_raw  = '0;
        n_grant    = 0;
        n_free_req = 0;
        n_push     = 0;
        capacity   = 0;
        rank       = 0;

        alloc_ready = clk_en && (state_q == ST_RUN) && (count_q >= ALLOC_MIN);
        for (int k = 0; k < ALLOC_PORTS; k++) begin
            alloc_phys[k] = free_list[wrap_add(head_q, rank)];
            if (alloc_req[k]) rank = rank + 1;
        end
        grant = alloc_ready && (|alloc_req);

        if (clk_en) begin
            mt_en_d   = '0;
            mt_addr_d = '0;
            mt_tag_d  = '0;
            unique case (state_q)
                ST_INIT: begin
                    list_we[0]    = 1'b1;
                    list_waddr[0] = init_idx_q;
                    list_wdata[0] = init_idx_q;
                    count_d       = count_q + 1'b1;
                    mt_en_d[0]    = 1'b1;
                    mt_addr_d[0]  = init_idx_q;
                    init_idx_d    = wrap_add(init_idx_q, 1);
                    tail_d        = wrap_add(init_idx_q, 1);
                    if (init_idx_q == LAST_IDX) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (grant) begin
                        n_grant = rank;
                        mt_en_d = alloc_req;
                        for (int k = 0; k < ALLOC_PORTS; k++) begin
                            if (alloc_req[k]) begin
                                mt_addr_d[k] = alloc_phys[k];
                                mt_tag_d[k]  = alloc_tag[k];
                            end
                        end
                        head_d = wrap_add(head_q, n_grant);
                    end
                    for (int p = 0; p < FREE_PORTS; p++) begin
                        if (free_valid[p]) n_free_req = n_free_req + 1;
                    end
                    count_raw = {1'b0, count_q} - (CNT_WIDTH + 1)'(n_grant)
                              + (CNT_WIDTH + 1)'(n_free_req);
                    overflow  = (count_raw > CELLS_W);
                    capacity  = CELLS - int'(count_q) + n_grant;
                    // Frees beyond capacity are dropped; lower ports claim space first.
                    for (int p = 0; p < FREE_PORTS; p++) begin
                        if (free_valid[p] && (n_push < capacity)) begin
                            list_we[p]    = 1'b1;
                            list_waddr[p] = wrap_add(tail_q, n_push);
                            list_wdata[p] = free_phys[p];
                            n_push        = n_push + 1;
                        end
                    end
                    tail_d = wrap_add(tail_q, n_push);
                    if (overflow) begin
                        count_d = CELLS_W[CNT_WIDTH-1:0];
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                        mt_en_d = '0;
                    end else begin
                        count_d = count_raw[CNT_WIDTH-1:0];
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            mt_en_q    <= '0;
            mt_addr_q  <= '0;
            mt_tag_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            err_q      <= err_d;
            mt_en_q    <= mt_en_d;
            mt_addr_q  <= mt_addr_d;
            mt_tag_q   <= mt_tag_d;
        end
    end

    // List storage needs no reset: INIT rewrites every entry before anything is read.
    always_ff @(posedge clk) begin
        for (int p = 0; p < FREE_PORTS; p++) begin
            if (list_we[p]) free_list[list_waddr[p]] <= list_wdata[p];
        end
    end

    // A pending write held across a clk_en-low stretch is delivered once clk_en returns.
    assign mt_wr_en     = clk_en ? mt_en_q : '0;
    assign mt_wr_addr   = mt_addr_q;
    assign mt_tag       = mt_tag_q;
    assign free_count   = count_q;
    assign init_done    = (state_q == ST_RUN);
    assign err_overflow = err_q;

`ifdef PHYS_ALLOC_STATS_EN
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            stall_cycles <= '0;
            alloc_total  <= '0;
        end else if (clk_en && (state_q == ST_RUN)) begin
            if ((|alloc_req) && !alloc_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (grant) begin
                alloc_total <= alloc_total + 32'(n_grant);
            end
        end
    end
`endif

endmodule

// File: tb/tb_phys_reg_alloc_ctrl.sv
// Self-checking bench for phys_reg_alloc_ctrl: queue-based free-list model, directed scenarios, then randomized traffic.
module tb_phys_reg_alloc_ctrl;

    localparam int CELLS = 128;
    localparam int AP    = 4;
    localparam int FP    = 4;
    localparam int PAW   = 7;
    localparam int VAW   = 8;
    localparam int CW    = 8;

    localparam int S_INIT = 0;
    localparam int S_RUN  = 1;
    localparam int S_ERR  = 2;

    logic                   clk;
    logic                   sync_rst;
    logic                   clk_en;
    logic [AP-1:0]          alloc_req;
    logic [AP-1:0][VAW-1:0] alloc_tag;
    logic                   alloc_ready;
    logic [AP-1:0][PAW-1:0] alloc_phys;
    logic [FP-1:0]          free_valid;
    logic [FP-1:0][PAW-1:0] free_phys;
    logic [AP-1:0]          mt_wr_en;
    logic [AP-1:0][PAW-1:0] mt_wr_addr;
    logic [AP-1:0][VAW-1:0] mt_tag;
    logic [CW-1:0]          free_count;
    logic                   init_done;
    logic                   err_overflow;
`ifdef PHYS_ALLOC_STATS_EN
    logic [31:0]            stall_cycles;
    logic [31:0]            alloc_total;
    logic [31:0]            m_stall;
    logic [31:0]            m_total;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: the free list is a plain queue of cell numbers.
    int        mq[$];
    int        outq[$];
    int        m_state;
    int        m_idx;
    bit        m_err;
    bit [AP-1:0] m_pen;
    int        m_paddr[AP];
    int        m_ptag[AP];

    phys_reg_alloc_ctrl dut (
        .clk          (clk),
        .sync_rst     (sync_rst),
        .clk_en       (clk_en),
        .alloc_req    (alloc_req),
        .alloc_tag    (alloc_tag),
        .alloc_ready  (alloc_ready),
        .alloc_phys   (alloc_phys),
        .free_valid   (free_valid),
        .free_phys    (free_phys),
        .mt_wr_en     (mt_wr_en),
        .mt_wr_addr   (mt_wr_addr),
        .mt_tag       (mt_tag),
        .free_count   (free_count),
        .init_done    (init_done),
        .err_overflow (err_overflow)
`ifdef PHYS_ALLOC_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .alloc_total  (alloc_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [AP-1:0] req,
                                 input logic [31:0] tags, input logic [FP-1:0] fv,
                                 input logic [27:0] fp);
        sync_rst   = r;
        clk_en     = e;
        alloc_req  = req;
        alloc_tag  = tags;
        free_valid = fv;
        free_phys  = fp;
    endtask

    function automatic bit model_ready();
        return clk_en && (m_state == S_RUN) && (mq.size() >= AP);
    endfunction

    task automatic checkOutput();
        bit er;
        int r;
        er = model_ready();
        check("alloc_ready", alloc_ready, er);
        check("free_count", free_count, mq.size());
        check("init_done", init_done, m_state == S_RUN);
        check("err_overflow", err_overflow, m_err);
        check("mt_wr_en", mt_wr_en, clk_en ? m_pen : '0);
        for (int k = 0; k < AP; k++) begin
            if (clk_en && m_pen[k]) begin
                check($sformatf("mt_wr_addr[%0d]", k), mt_wr_addr[k], m_paddr[k]);
                check($sformatf("mt_tag[%0d]", k), mt_tag[k], m_ptag[k]);
            end
        end
        if (er) begin
            r = 0;
            for (int k = 0; k < AP; k++) begin
                if (alloc_req[k]) begin
                    check($sformatf("alloc_phys[%0d]", k), alloc_phys[k], mq[r]);
                    r++;
                end
            end
        end
`ifdef PHYS_ALLOC_STATS_EN
        check("stall_cycles", stall_cycles, m_stall);
        check("alloc_total", alloc_total, m_total);
`endif
    endtask

    task automatic modelStep();
        bit er;
        bit ovf;
        int g;
        er  = model_ready();
        ovf = 1'b0;
        if (sync_rst) begin
            mq.delete();
            outq.delete();
            m_state = S_INIT;
            m_idx   = 0;
            m_err   = 1'b0;
            m_pen   = '0;
`ifdef PHYS_ALLOC_STATS_EN
            m_stall = '0;
            m_total = '0;
`endif
            return;
        end
        if (!clk_en) return;
`ifdef PHYS_ALLOC_STATS_EN
        if (m_state == S_RUN && (|alloc_req) && !er && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
        m_pen = '0;
        for (int k = 0; k < AP; k++) begin
            m_paddr[k] = 0;
            m_ptag[k]  = 0;
        end
        if (m_state == S_INIT) begin
            mq.push_back(m_idx);
            m_pen[0]   = 1'b1;
            m_paddr[0] = m_idx;
            m_idx++;
            if (m_idx == CELLS) begin
                m_state = S_RUN;
                m_idx   = 0;
            end
        end else if (m_state == S_RUN) begin
            if (er) begin
                for (int k = 0; k < AP; k++) begin
                    if (alloc_req[k]) begin
                        g = mq.pop_front();
                        m_pen[k]   = 1'b1;
                        m_paddr[k] = g;
                        m_ptag[k]  = alloc_tag[k];
                        outq.push_back(g);
`ifdef PHYS_ALLOC_STATS_EN
                        m_total++;
`endif
                    end
                end
            end
            for (int p = 0; p < FP; p++) begin
                if (free_valid[p]) begin
                    if (mq.size() < CELLS) mq.push_back(int'(free_phys[p]));
                    else ovf = 1'b1;
                end
            end
            if (ovf) begin
                m_err   = 1'b1;
                m_state = S_ERR;
                m_pen   = '0;
            end
        end
    endtask

    // One clock: compare mid-cycle, advance the model on the edge, leave inputs changeable just after it.
    task automatic tick();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    initial begin
        logic [FP-1:0]          fv;
        logic [FP-1:0][PAW-1:0] fpv;
        logic                   en;
        logic                   rst;
        int                     idx;

        applyStimulus(1'b1, 1'b1, '0, '0, '0, '0);
        @(posedge clk);
        modelStep();
        #1;
        tick();
        tick();

        applyStimulus(1'b0, 1'b1, '0, '0, '0, '0);
        #1;
        check("rst_free_count", free_count, 0);
        check("rst_init_done", init_done, 0);
        check("rst_alloc_ready", alloc_ready, 0);
        check("rst_mt_wr_en", mt_wr_en, 0);
        repeat (60) tick();
        #1;
        check("init_partial_count", free_count, 60);

        applyStimulus(1'b1, 1'b1, '0, '0, '0, '0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 4'hF, 28'h1234567);
        #1;
        check("restart_count", free_count, 0);
        repeat (128) tick();

        applyStimulus(1'b0, 1'b1, 4'hF, {8'd8, 8'd7, 8'd6, 8'd5}, '0, '0);
        #1;
        check("init_done_high", init_done, 1);
        check("full_list_count", free_count, 128);
        check("ready_after_init", alloc_ready, 1);
        for (int k = 0; k < AP; k++) check($sformatf("first_phys[%0d]", k), alloc_phys[k], k);
        tick();

        applyStimulus(1'b0, 1'b1, 4'hF, $urandom(), '0, '0);
        #1;
        check("first_mt_en", mt_wr_en, 4'hF);
        for (int k = 0; k < AP; k++) begin
            check($sformatf("first_mt_addr[%0d]", k), mt_wr_addr[k], k);
            check($sformatf("first_mt_tag[%0d]", k), mt_tag[k], k + 5);
        end
        check("count_after_first", free_count, 124);
        tick();
        repeat (30) begin
            applyStimulus(1'b0, 1'b1, 4'hF, $urandom(), '0, '0);
            tick();
        end

        applyStimulus(1'b0, 1'b1, 4'hF, $urandom(), '0, '0);
        #1;
        check("exhausted_count", free_count, 0);
        check("exhausted_ready", alloc_ready, 0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'hF, $urandom(), 4'b0001, {21'd0, 7'd9});
        tick();
        applyStimulus(1'b0, 1'b1, 4'hF, $urandom(), 4'b1110, {7'd12, 7'd11, 7'd10, 7'd0});
        #1;
        check("one_free_count", free_count, 1);
        check("one_free_ready", alloc_ready, 0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b1010, {8'd44, 8'd33, 8'd22, 8'd11}, '0, '0);
        #1;
        check("four_free_count", free_count, 4);
        check("four_free_ready", alloc_ready, 1);
        check("sparse_phys[1]", alloc_phys[1], 9);
        check("sparse_phys[3]", alloc_phys[3], 10);
        tick();
        applyStimulus(1'b0, 1'b1, '0, '0, '0, '0);
        #1;
        check("sparse_mt_en", mt_wr_en, 4'b1010);
        check("sparse_count", free_count, 2);
        tick();

        repeat (31) begin
            applyStimulus(1'b0, 1'b1, '0, '0, 4'hF, $urandom());
            tick();
        end
        applyStimulus(1'b0, 1'b1, '0, '0, 4'b0001, $urandom());
        tick();
        applyStimulus(1'b0, 1'b1, '0, '0, 4'b0111, $urandom());
        #1;
        check("pre_overflow_count", free_count, 127);
        tick();
        applyStimulus(1'b0, 1'b1, 4'hF, $urandom(), 4'hF, $urandom());
        #1;
        check("overflow_flag", err_overflow, 1);
        check("overflow_count", free_count, 128);
        check("error_ready", alloc_ready, 0);
        repeat (4) tick();

        applyStimulus(1'b1, 1'b1, '0, '0, '0, '0);
        tick();
        applyStimulus(1'b0, 1'b1, '0, '0, '0, '0);
        repeat (128) tick();
        applyStimulus(1'b0, 1'b1, 4'hF, $urandom(), '0, '0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'hF, $urandom(), 4'hF, $urandom());
        repeat (10) begin
            #1;
            check("frozen_count", free_count, 124);
            check("frozen_mt_en", mt_wr_en, 0);
            tick();
        end

        for (int c = 0; c < 2000; c++) begin
            rst = (c == 1000);
            en  = ($urandom_range(0, 7) != 0);
            fv  = '0;
            fpv = '0;
            if (en && !rst && m_state == S_RUN) begin
                for (int p = 0; p < FP; p++) begin
                    if (outq.size() > 0 && $urandom_range(0, 2) == 0) begin
                        idx    = $urandom_range(0, outq.size() - 1);
                        fpv[p] = PAW'(outq[idx]);
                        outq.delete(idx);
                        fv[p]  = 1'b1;
                    end
                end
            end
            applyStimulus(rst, en, AP'($urandom()), $urandom(), fv, fpv);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
